// File: rtl/inst_sram_responder_pkg.sv
// Shared definitions for the instruction-SRAM responder and its address translator.
package inst_sram_responder_pkg;

  // kseg0/kseg1 strip the top three address bits to reach physical space
  localparam logic [31:0] KSEG_MASK          = 32'h1FFF_FFFF;

  // Physical address that maps onto word index 0 of the instruction memory
  localparam logic [31:0] DEFAULT_BASE_PHYS  = 32'h1FC0_0000;

  // Address the fetch stage presents straight out of reset (one word below the boot ROM)
  localparam logic [31:0] FETCH_RESET_VECTOR = 32'hBFBF_FFFC;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Virtual-to-physical mapping: only kseg0/kseg1 (addr[31:30]==2'b10) are masked
  function automatic logic [31:0] kseg_to_phys(input logic [31:0] vaddr);
    return (vaddr[31:30] == 2'b10) ? (vaddr & KSEG_MASK) : vaddr;
  endfunction

endpackage

// File: rtl/inst_sram_responder_xlate.sv
// Combinational virtual byte address -> memory word index plus error flag.
// BASE_PHYS is expected to be word aligned, so the low offset bits equal addr[1:0].
module imem_addr_xlate
  import inst_sram_responder_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_PHYS = DEFAULT_BASE_PHYS
) (
  input  logic [31:0]       i_addr,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_err
);

  logic [31:0] w_phys;
  logic [31:0] w_off;
  logic        w_misaligned;
  logic        w_below;
  logic        w_above;

  assign w_phys = kseg_to_phys(i_addr);

  // 32-bit unsigned offset; an address below the base wraps to a huge value
  assign w_off = w_phys - BASE_PHYS;

  assign w_misaligned = (i_addr[1:0] != 2'b00) | (w_off[1:0] != 2'b00);
  assign w_below      = (w_phys < BASE_PHYS);

  // Any offset bit above the window means phys >= BASE_PHYS + 4*2^ADDR_W
  assign w_above      = |w_off[31:ADDR_W+2];

  assign o_idx = w_off[ADDR_W+1:2];
  assign o_err = w_misaligned | w_below | w_above;

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction-SRAM responder: word-addressed memory behind the fetch stage with
// a fixed number of wait states, a stall request while an access is in flight,
// and a backdoor preload port that always wins over a front-side write.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_PHYS   = DEFAULT_BASE_PHYS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_wen,
  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_wdata,
  output logic [31:0]       inst_sram_rdata,
  output logic              rdata_valid,
  output logic              stallreq,
  output logic              addr_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_idx,
  input  logic [31:0]       load_data
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic       HAS_WAIT  = (WAIT_CYCLES != 0);
  localparam int         DEPTH     = 1 << ADDR_W;

  state_t            r_state;
  state_t            w_nextState;
  logic [3:0]        r_cnt;
  logic [3:0]        w_nextCnt;

  logic [ADDR_W-1:0] w_idx;
  logic              w_err;

  logic [ADDR_W-1:0] r_idx;
  logic [3:0]        r_wen;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic [31:0]       r_rdata;
  logic              r_addrErr;
  logic [31:0]       r_mem [0:DEPTH-1];

  logic              w_accept;
  logic              w_fromLive;
  logic              w_fromLatch;
  logic              w_complete;
  logic [ADDR_W-1:0] w_accIdx;
  logic [3:0]        w_accWen;
  logic [31:0]       w_accWdata;
  logic              w_accErr;
  logic              w_commitWr;
  logic [31:0]       w_mergedWord;

  imem_addr_xlate #(
    .ADDR_W    (ADDR_W),
    .BASE_PHYS (BASE_PHYS)
  ) u_xlate (
    .i_addr (inst_sram_addr),
    .o_idx  (w_idx),
    .o_err  (w_err)
  );

  // A request is taken in IDLE or in the RESP cycle; the reset term keeps a
  // request presented during reset from reaching the (unreset) memory array
  assign w_accept = rst & inst_sram_en & (r_state != ST_WAIT);

  // Without wait states the access completes on the accept edge from live inputs;
  // otherwise it completes from the latched request at the end of WAIT
  assign w_fromLive  = w_accept & ~HAS_WAIT;
  assign w_fromLatch = (r_state == ST_WAIT) & (r_cnt <= 4'd1);
  assign w_complete  = w_fromLive | w_fromLatch;

  assign w_accIdx   = w_fromLive ? w_idx           : r_idx;
  assign w_accWen   = w_fromLive ? inst_sram_wen   : r_wen;
  assign w_accWdata = w_fromLive ? inst_sram_wdata : r_wdata;
  assign w_accErr   = w_fromLive ? w_err           : r_err;
  assign w_commitWr = w_complete & ~w_accErr & (w_accWen != 4'b0000);

  // Next-state and wait-counter logic
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept) begin
          if (HAS_WAIT) begin
            w_nextState = ST_WAIT;
            w_nextCnt   = WAIT_LOAD;
          end else begin
            w_nextState = ST_RESP;
          end
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_nextCnt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_nextState = ST_RESP;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextCnt   = 4'd0;
      end
    endcase
  end

  // State and wait counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Capture the request at the accept edge so WAIT can ignore the bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_wen   <= 4'd0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= w_idx;
      r_wen   <= inst_sram_wen;
      r_wdata <= inst_sram_wdata;
      r_err   <= w_err;
    end
  end

  // Response data: old word (read-before-write) or zero on an address error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata   <= 32'd0;
      r_addrErr <= 1'b0;
    end else if (w_complete) begin
      r_rdata   <= w_accErr ? 32'd0 : r_mem[w_accIdx];
      r_addrErr <= w_accErr;
    end
  end

  // Byte-merge the write data into the currently stored word
  always_comb begin
    w_mergedWord = r_mem[w_accIdx];
    for (int b = 0; b < 4; b++) begin
      if (w_accWen[b]) begin
        w_mergedWord[8*b +: 8] = w_accWdata[8*b +: 8];
      end
    end
  end

  // Memory array is never cleared; the backdoor assignment comes last so it wins
  always_ff @(posedge clk) begin
    if (w_commitWr) begin
      r_mem[w_accIdx] <= w_mergedWord;
    end
    if (load_en) begin
      r_mem[load_idx] <= load_data;
    end
  end

  assign inst_sram_rdata = r_rdata;
  assign rdata_valid     = (r_state == ST_RESP);
  assign addr_err        = r_addrErr;
  assign stallreq        = rst & ((r_state == ST_WAIT) |
                                  (HAS_WAIT & inst_sram_en & (r_state == ST_IDLE)));

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: one instance with no wait states, one with three.
module tb_inst_sram_responder;
  import inst_sram_responder_pkg::*;

  localparam int          ADDR_W = 12;
  localparam int          DEPTH  = 4096;
  localparam logic [31:0] BASE   = 32'h1FC0_0000;
  localparam int          NVEC   = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]              rstN;
  logic [1:0]              en;
  logic [1:0][3:0]         wen;
  logic [1:0][31:0]        addr;
  logic [1:0][31:0]        wdata;
  logic [1:0][31:0]        rdata;
  logic [1:0]              valid;
  logic [1:0]              stall;
  logic [1:0]              aerr;
  logic [1:0]              loadEn;
  logic [1:0][ADDR_W-1:0]  loadIdx;
  logic [1:0][31:0]        loadData;

  inst_sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0), .BASE_PHYS(BASE)) dut0 (
    .clk(clk), .rst(rstN[0]), .inst_sram_en(en[0]), .inst_sram_wen(wen[0]),
    .inst_sram_addr(addr[0]), .inst_sram_wdata(wdata[0]), .inst_sram_rdata(rdata[0]),
    .rdata_valid(valid[0]), .stallreq(stall[0]), .addr_err(aerr[0]),
    .load_en(loadEn[0]), .load_idx(loadIdx[0]), .load_data(loadData[0])
  );

  inst_sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3), .BASE_PHYS(BASE)) dut1 (
    .clk(clk), .rst(rstN[1]), .inst_sram_en(en[1]), .inst_sram_wen(wen[1]),
    .inst_sram_addr(addr[1]), .inst_sram_wdata(wdata[1]), .inst_sram_rdata(rdata[1]),
    .rdata_valid(valid[1]), .stallreq(stall[1]), .addr_err(aerr[1]),
    .load_en(loadEn[1]), .load_idx(loadIdx[1]), .load_data(loadData[1])
  );

  int nChecks = 0;
  int nFails  = 0;

  // Reference memory contents, one image per instance
  logic [31:0] mdl [2][DEPTH];

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vector_t;

  vector_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int d, input logic e, input logic [3:0] w,
                               input logic [31:0] a, input logic [31:0] wd);
    en[d]    = e;
    wen[d]   = w;
    addr[d]  = a;
    wdata[d] = wd;
  endtask

  // Address rules computed with plain arithmetic on 64-bit values
  task automatic refXlate(input logic [31:0] a, output int idx, output bit err);
    longint unsigned av;
    longint unsigned phys;
    longint unsigned b;
    av   = {32'd0, a};
    b    = {32'd0, BASE};
    phys = (av / 64'h4000_0000 == 2) ? av % 64'h2000_0000 : av;
    err  = (av % 4 != 0) || (phys < b) || (phys >= b + 4 * DEPTH);
    idx  = err ? 0 : int'((phys - b) / 4);
  endtask

  // Expected response of one access, then apply its write to the model
  task automatic refAccess(input int d, input logic [3:0] w, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] expR, output logic expE);
    int idx;
    bit err;
    refXlate(a, idx, err);
    expE = err;
    expR = err ? 32'd0 : mdl[d][idx];
    if (!err && w != 4'd0) begin
      for (int b = 0; b < 4; b++) begin
        if (w[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic loadWord(input int d, input int idx, input logic [31:0] data);
    @(negedge clk);
    loadEn[d]   = 1'b1;
    loadIdx[d]  = ADDR_W'(idx);
    loadData[d] = data;
    @(posedge clk);
    #1;
    loadEn[d] = 1'b0;
    mdl[d][idx] = data;
  endtask

  // One complete access from IDLE, request held until the response cycle
  task automatic doAccess(input int d, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] expR,
                          input logic expE, input string tag);
    int waits;
    waits = (d == 0) ? 0 : 3;
    @(negedge clk);
    applyStimulus(d, 1'b1, w, a, wd);
    #1;
    checkOutput({tag, " stall_accept"}, 32'(stall[d]), 32'(waits > 0));
    @(posedge clk);
    #1;
    for (int c = 0; c < waits; c++) begin
      checkOutput({tag, " stall_wait"}, 32'(stall[d]), 32'd1);
      checkOutput({tag, " valid_wait"}, 32'(valid[d]), 32'd0);
      @(posedge clk);
      #1;
    end
    applyStimulus(d, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput({tag, " valid"}, 32'(valid[d]), 32'd1);
    checkOutput({tag, " rdata"}, rdata[d], expR);
    checkOutput({tag, " addr_err"}, 32'(aerr[d]), 32'(expE));
    checkOutput({tag, " stall_resp"}, 32'(stall[d]), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, " valid_pulse"}, 32'(valid[d]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] eR;
    logic        eE;
    logic [3:0]  rw;
    logic [31:0] ra;
    logic [31:0] rd;
    int          sel;

    vecs[0]  = '{4'h0, 32'hBFC0_0000, 32'h0,         32'h2408_0001, 1'b0};
    vecs[1]  = '{4'h0, 32'hBFC0_0004, 32'h0,         32'h2409_0002, 1'b0};
    vecs[2]  = '{4'h0, FETCH_RESET_VECTOR, 32'h0,    32'h0,         1'b1};
    vecs[3]  = '{4'h0, 32'hBFC0_0000, 32'h0,         32'h2408_0001, 1'b0};
    vecs[4]  = '{4'h3, 32'h9FC0_0008, 32'h1122_3344, 32'hAABB_CCDD, 1'b0};
    vecs[5]  = '{4'h0, 32'hBFC0_0008, 32'h0,         32'hAABB_3344, 1'b0};
    vecs[6]  = '{4'h0, 32'hBFC0_0002, 32'h0,         32'h0,         1'b1};
    vecs[7]  = '{4'h0, 32'h1FC0_0004, 32'h0,         32'h2409_0002, 1'b0};
    vecs[8]  = '{4'h0, 32'hBFC0_4000, 32'h0,         32'h0,         1'b1};
    vecs[9]  = '{4'h0, 32'hBFC0_3FFC, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{4'hF, 32'hBFBF_FFFC, 32'h9999_9999, 32'h0,         1'b1};
    vecs[11] = '{4'h0, 32'hDFC0_0000, 32'h0,         32'h0,         1'b1};
    vecs[12] = '{4'h8, 32'hBFC0_3FFC, 32'h7700_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[13] = '{4'h0, 32'hBFC0_3FFC, 32'h0,         32'h77AD_BEEF, 1'b0};
    vecs[14] = '{4'h0, 32'h0000_0000, 32'h0,         32'h0,         1'b1};

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) mdl[d][i] = 32'd0;
      applyStimulus(d, 1'b0, 4'd0, 32'd0, 32'd0);
      loadEn[d]   = 1'b0;
      loadIdx[d]  = '0;
      loadData[d] = 32'd0;
    end

    // Asynchronous reset with the clock free-running
    rstN = 2'b11;
    #1 rstN = 2'b00;
    #2;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset_rdata_d%0d", d), rdata[d], 32'd0);
      checkOutput($sformatf("reset_valid_d%0d", d), 32'(valid[d]), 32'd0);
      checkOutput($sformatf("reset_err_d%0d", d), 32'(aerr[d]), 32'd0);
      checkOutput($sformatf("reset_stall_d%0d", d), 32'(stall[d]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rstN = 2'b11;

    for (int d = 0; d < 2; d++) begin
      loadWord(d, 0, 32'h2408_0001);
      loadWord(d, 1, 32'h2409_0002);
      loadWord(d, 2, 32'hAABB_CCDD);
      loadWord(d, 5, 32'h5555_6666);
      loadWord(d, 6, 32'h6666_6666);
      loadWord(d, DEPTH - 1, 32'hDEAD_BEEF);
      loadWord(d, 3, $urandom);
      loadWord(d, 4, $urandom);
      for (int i = 7; i < 32; i++) loadWord(d, i, $urandom);
    end

    // Zero wait states: back-to-back reads on consecutive cycles, never stalling
    @(negedge clk);
    applyStimulus(0, 1'b1, 4'd0, 32'hBFC0_0000, 32'd0);
    #1;
    checkOutput("b2b0 stall_first", 32'(stall[0]), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b1, 4'd0, 32'hBFC0_0004, 32'd0);
    checkOutput("b2b0 valid_first", 32'(valid[0]), 32'd1);
    checkOutput("b2b0 rdata_first", rdata[0], 32'h2408_0001);
    checkOutput("b2b0 stall_second", 32'(stall[0]), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("b2b0 valid_second", 32'(valid[0]), 32'd1);
    checkOutput("b2b0 rdata_second", rdata[0], 32'h2409_0002);
    @(posedge clk);
    #1;
    checkOutput("b2b0 valid_idle", 32'(valid[0]), 32'd0);
    checkOutput("b2b0 rdata_hold", rdata[0], 32'h2409_0002);

    // Three wait states with the address held: four stall cycles, valid in the fifth
    doAccess(1, 4'd0, 32'hBFC0_0004, 32'd0, 32'h2409_0002, 1'b0, "wait3_hold");

    // Table of directed vectors, applied to both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NVEC; i++) begin
        refAccess(d, vecs[i].wen, vecs[i].addr, vecs[i].wdata, eR, eE);
        doAccess(d, vecs[i].wen, vecs[i].addr, vecs[i].wdata,
                 vecs[i].expRdata, vecs[i].expErr, $sformatf("vec%0d_d%0d", i, d));
      end
    end

    // Three wait states: a new request accepted in the RESP cycle
    @(negedge clk);
    applyStimulus(1, 1'b1, 4'd0, 32'hBFC0_0000, 32'd0);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1, 1'b1, 4'd0, 32'hBFC0_0004, 32'd0);
    #1;
    checkOutput("tput3 valid_first", 32'(valid[1]), 32'd1);
    checkOutput("tput3 rdata_first", rdata[1], 32'h2408_0001);
    checkOutput("tput3 stall_resp", 32'(stall[1]), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("tput3 stall_wait", 32'(stall[1]), 32'd1);
    checkOutput("tput3 valid_wait", 32'(valid[1]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("tput3 valid_second", 32'(valid[1]), 32'd1);
    checkOutput("tput3 rdata_second", rdata[1], 32'h2409_0002);
    @(posedge clk);
    #1;

    // Backdoor load and front-side write on the same edge and index
    @(negedge clk);
    applyStimulus(0, 1'b1, 4'hF, 32'hBFC0_0018, 32'h1111_1111);
    loadEn[0]   = 1'b1;
    loadIdx[0]  = ADDR_W'(6);
    loadData[0] = 32'h2222_2222;
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 4'd0, 32'd0, 32'd0);
    loadEn[0] = 1'b0;
    checkOutput("bdoor valid", 32'(valid[0]), 32'd1);
    checkOutput("bdoor rdata_old", rdata[0], 32'h6666_6666);
    mdl[0][6] = 32'h2222_2222;
    @(posedge clk);
    #1;
    doAccess(0, 4'd0, 32'hBFC0_0018, 32'd0, 32'h2222_2222, 1'b0, "bdoor_readback");

    // Reset during WAIT with a write pending
    doAccess(1, 4'd0, 32'hBFC0_0014, 32'd0, 32'h5555_6666, 1'b0, "rstmid_pre");
    @(negedge clk);
    applyStimulus(1, 1'b1, 4'hF, 32'hBFC0_0014, 32'h1234_5678);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rstmid stall_before", 32'(stall[1]), 32'd1);
    @(negedge clk);
    rstN[1] = 1'b0;
    #1;
    checkOutput("rstmid stall", 32'(stall[1]), 32'd0);
    checkOutput("rstmid valid", 32'(valid[1]), 32'd0);
    checkOutput("rstmid rdata", rdata[1], 32'd0);
    checkOutput("rstmid err", 32'(aerr[1]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    applyStimulus(1, 1'b0, 4'd0, 32'd0, 32'd0);
    rstN[1] = 1'b1;
    doAccess(1, 4'd0, 32'hBFC0_0014, 32'd0, 32'h5555_6666, 1'b0, "rstmid_after");

    // Randomized accesses against the reference model
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 7) == 0) loadWord(d, $urandom_range(0, 31), $urandom);
        sel = $urandom_range(0, 9);
        case (sel)
          0: begin
            ra = $urandom;
            ra[31:30] = 2'b11;
          end
          1: ra = 32'hBFC0_0000 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
          2: ra = 32'($urandom_range(0, 32'h1FBF_FFFC)) & 32'hFFFF_FFFC;
          default: ra = (($urandom_range(0, 1) == 0) ? 32'h9FC0_0000 : 32'hBFC0_0000)
                        + 32'(4 * $urandom_range(0, 31));
        endcase
        rw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        rd = $urandom;
        refAccess(d, rw, ra, rd, eR, eE);
        doAccess(d, rw, ra, rd, eR, eE, $sformatf("rand%0d_d%0d", n, d));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
